// File: rtl/ifu_pc_fetch.sv
// Instruction fetch unit for the multi-cycle RV core.
// Owns the architectural PC and keeps one instruction in flight at a time.
// The fetched word is presented to decode over a valid/ready handshake.
module ifu_pc_fetch #(
    parameter int unsigned               CPU_WIDTH = 32,
    parameter logic [CPU_WIDTH-1:0]      RESET_PC  = CPU_WIDTH'(32'h8000_0000)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [CPU_WIDTH-1:0] next_pc,
    input  logic                 pc_update,
    output logic [CPU_WIDTH-1:0] curr_pc,
    output logic                 imem_req_valid,
    output logic [CPU_WIDTH-1:0] imem_req_addr,
    input  logic                 imem_req_ready,
    input  logic                 imem_rsp_valid,
    input  logic [31:0]          imem_rsp_data,
    input  logic                 imem_rsp_err,
    output logic                 inst_valid,
    output logic [31:0]          inst,
    output logic [CPU_WIDTH-1:0] inst_pc,
    input  logic                 inst_ready,
    output logic                 fetch_fault,
    output logic [31:0]          fetch_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_HOLD,
        S_EXEC,
        S_FAULT
    } state_t;

    state_t state_q;
    state_t state_d;

    logic req_fire;
    logic rsp_ok;
    logic rsp_bad;
    logic dec_fire;
    logic redirect;
    logic redirect_ok;

    // Handshake qualifiers; each is gated by its own state so stray inputs are ignored.
    always_comb begin
        req_fire    = (state_q == S_REQ)  && imem_req_ready;
        rsp_ok      = (state_q == S_WAIT) && imem_rsp_valid && !imem_rsp_err;
        rsp_bad     = (state_q == S_WAIT) && imem_rsp_valid &&  imem_rsp_err;
        dec_fire    = (state_q == S_HOLD) && inst_ready;
        redirect    = (state_q == S_EXEC) && pc_update;
        redirect_ok = redirect && (next_pc[1:0] == 2'b00);
    end

    // Next-state logic; S_FAULT is absorbing and only reset leaves it.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  state_d = S_REQ;
            S_REQ:   if (req_fire) state_d = S_WAIT;
            S_WAIT: begin
                if (rsp_ok)       state_d = S_HOLD;
                else if (rsp_bad) state_d = S_FAULT;
            end
            S_HOLD:  if (dec_fire) state_d = S_EXEC;
            S_EXEC: begin
                if (redirect_ok)   state_d = S_REQ;
                else if (redirect) state_d = S_FAULT;
            end
            S_FAULT: state_d = S_FAULT;
            default: state_d = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // PC, latched instruction and retire-side counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            curr_pc   <= RESET_PC;
            inst      <= '0;
            inst_pc   <= '0;
            fetch_cnt <= '0;
        end else begin
            if (redirect_ok) curr_pc <= next_pc;
            if (rsp_ok) begin
                inst    <= imem_rsp_data;
                inst_pc <= curr_pc;
            end
            if (dec_fire) fetch_cnt <= fetch_cnt + 32'd1;
        end
    end

    // Outputs are pure decodes of the registered state.
    always_comb begin
        imem_req_valid = (state_q == S_REQ);
        imem_req_addr  = curr_pc;
        inst_valid     = (state_q == S_HOLD);
        fetch_fault    = (state_q == S_FAULT);
    end

endmodule

// File: tb/tb_ifu_pc_fetch.sv
// Directed self-checking bench for ifu_pc_fetch.
module tb_ifu_pc_fetch;

    logic        clk;
    logic        rst;
    logic [31:0] next_pc;
    logic        pc_update;
    logic [31:0] curr_pc;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        imem_rsp_err;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_ready;
    logic        fetch_fault;
    logic [31:0] fetch_cnt;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    ifu_pc_fetch #(
        .CPU_WIDTH (32),
        .RESET_PC  (32'h8000_0000)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .next_pc        (next_pc),
        .pc_update      (pc_update),
        .curr_pc        (curr_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .imem_rsp_err   (imem_rsp_err),
        .inst_valid     (inst_valid),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .inst_ready     (inst_ready),
        .fetch_fault    (fetch_fault),
        .fetch_cnt      (fetch_cnt)
    );

    // 10 ns core clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard time limit so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1, "time limit");
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst            = 1'b1;
        next_pc        = '0;
        pc_update      = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        imem_rsp_err   = 1'b0;
        inst_ready     = 1'b0;

        // ---- reset sequence
        repeat (3) step();
        check_eq("rst_curr_pc",   curr_pc,        32'h8000_0000);
        check_eq("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
        check_eq("rst_inst_val",  {31'd0, inst_valid},     32'd0);
        check_eq("rst_fault",     {31'd0, fetch_fault},    32'd0);
        check_eq("rst_cnt",       fetch_cnt,      32'd0);
        check_eq("rst_inst",      inst,           32'd0);
        check_eq("rst_inst_pc",   inst_pc,        32'd0);
        rst = 1'b0;
        step();
        check_eq("rel_req_valid", {31'd0, imem_req_valid}, 32'd1);
        check_eq("rel_req_addr",  imem_req_addr,  32'h8000_0000);

        // ---- zero-wait memory, decode always ready
        imem_req_ready = 1'b1;
        inst_ready     = 1'b1;
        step();                                   // handshake -> S_WAIT
        check_eq("zw_wait_req",   {31'd0, imem_req_valid}, 32'd0);
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h0000_0013;
        step();                                   // response -> S_HOLD
        imem_rsp_valid = 1'b0;
        check_eq("zw_inst_valid", {31'd0, inst_valid},     32'd1);
        check_eq("zw_inst",       inst,           32'h0000_0013);
        check_eq("zw_inst_pc",    inst_pc,        32'h8000_0000);
        step();                                   // accept -> S_EXEC
        check_eq("zw_inst_drop",  {31'd0, inst_valid},     32'd0);
        check_eq("zw_cnt",        fetch_cnt,      32'd1);
        inst_ready = 1'b0;
        pc_update  = 1'b1;
        next_pc    = 32'h8000_0004;
        step();                                   // redirect -> S_REQ
        pc_update  = 1'b0;
        check_eq("zw_curr_pc",    curr_pc,        32'h8000_0004);
        check_eq("zw_req_valid",  {31'd0, imem_req_valid}, 32'd1);
        check_eq("zw_req_addr",   imem_req_addr,  32'h8000_0004);

        // ---- back-pressure on both sides
        for (int i = 0; i < 4; i++) begin
            step();
            check_eq("bp_req_hold",  {31'd0, imem_req_valid}, 32'd1);
            check_eq("bp_addr_hold", imem_req_addr, 32'h8000_0004);
        end
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0;
        check_eq("bp_req_taken",  {31'd0, imem_req_valid}, 32'd0);
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h0010_0093;
        step();
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'hFFFF_FFFF;
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq("bp_inst_valid", {31'd0, inst_valid}, 32'd1);
            check_eq("bp_inst",       inst,      32'h0010_0093);
            check_eq("bp_inst_pc",    inst_pc,   32'h8000_0004);
            check_eq("bp_cnt_hold",   fetch_cnt, 32'd1);
        end
        inst_ready = 1'b1;
        step();
        inst_ready = 1'b0;
        check_eq("bp_cnt_once",   fetch_cnt,      32'd2);
        check_eq("bp_exec_iv",    {31'd0, inst_valid},     32'd0);

        // ---- misaligned redirect
        pc_update = 1'b1;
        next_pc   = 32'h8000_0102;
        step();
        pc_update = 1'b0;
        check_eq("mis_fault",     {31'd0, fetch_fault},    32'd1);
        check_eq("mis_curr_pc",   curr_pc,        32'h8000_0004);
        imem_req_ready = 1'b1;
        pc_update      = 1'b1;
        next_pc        = 32'h8000_0100;
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq("mis_no_req",   {31'd0, imem_req_valid}, 32'd0);
            check_eq("mis_sticky",   {31'd0, fetch_fault},    32'd1);
            check_eq("mis_pc_still", curr_pc,   32'h8000_0004);
        end
        pc_update      = 1'b0;
        imem_req_ready = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_eq("mis_rst_fault", {31'd0, fetch_fault},    32'd0);
        check_eq("mis_rst_pc",    curr_pc,        32'h8000_0000);
        check_eq("mis_rst_cnt",   fetch_cnt,      32'd0);
        step();                                   // S_IDLE -> S_REQ

        // ---- stray response in S_REQ, stray pc_update in S_HOLD, then bus error
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hBAD0_BAD0;
        step();
        imem_rsp_valid = 1'b0;
        check_eq("stray_rsp_req", {31'd0, imem_req_valid}, 32'd1);
        check_eq("stray_rsp_iv",  {31'd0, inst_valid},     32'd0);
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hDEAD_BEEF;
        step();
        imem_rsp_valid = 1'b0;
        check_eq("be_inst",       inst,           32'hDEAD_BEEF);
        pc_update = 1'b1;
        next_pc   = 32'h1234_0000;
        step();
        pc_update = 1'b0;
        check_eq("stray_pcu_iv",  {31'd0, inst_valid},     32'd1);
        check_eq("stray_pcu_pc",  curr_pc,        32'h8000_0000);
        inst_ready = 1'b1;
        step();
        inst_ready = 1'b0;
        check_eq("be_cnt",        fetch_cnt,      32'd1);
        pc_update = 1'b1;
        next_pc   = 32'h8000_0008;
        step();
        pc_update = 1'b0;
        check_eq("be_req_addr",   imem_req_addr,  32'h8000_0008);
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_err   = 1'b1;
        imem_rsp_data  = 32'h0000_00EF;
        step();
        imem_rsp_valid = 1'b0;
        imem_rsp_err   = 1'b0;
        for (int i = 0; i < 2; i++) begin
            check_eq("be_fault",     {31'd0, fetch_fault},    32'd1);
            check_eq("be_no_iv",     {31'd0, inst_valid},     32'd0);
            check_eq("be_no_req",    {31'd0, imem_req_valid}, 32'd0);
            check_eq("be_inst_keep", inst,     32'hDEAD_BEEF);
            step();
        end

        // ---- reset mid-request, late response after release
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        imem_req_ready = 1'b1;
        step();                                   // now in S_WAIT
        imem_req_ready = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h0000_0055;
        step();                                   // S_IDLE -> S_REQ, rsp ignored
        check_eq("late_req",      {31'd0, imem_req_valid}, 32'd1);
        check_eq("late_addr",     imem_req_addr,  32'h8000_0000);
        step();                                   // still in S_REQ, rsp ignored
        imem_rsp_valid = 1'b0;
        check_eq("late_req2",     {31'd0, imem_req_valid}, 32'd1);
        check_eq("late_no_iv",    {31'd0, inst_valid},     32'd0);
        check_eq("late_inst",     inst,           32'd0);

        // ---- fetch_cnt wrap
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h0000_0073;
        step();
        imem_rsp_valid = 1'b0;
        check_eq("wrap_iv",       {31'd0, inst_valid},     32'd1);
        force dut.fetch_cnt = 32'hFFFF_FFFF;
        #1;
        release dut.fetch_cnt;
        #1;
        check_eq("wrap_preset",   fetch_cnt,      32'hFFFF_FFFF);
        inst_ready = 1'b1;
        step();
        inst_ready = 1'b0;
        check_eq("wrap_cnt",      fetch_cnt,      32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
